// File: rtl/axi_tdd_ng_sequencer.sv
// TDD frame sequencer: drives the frame/delay counter, state and profile index
// consumed by the per-channel on/off comparators.
module axi_tdd_ng_sequencer #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int NUM_PROFILES      = 4,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   tdd_enable,
  input  logic                                   tdd_stop_req,
  input  logic                                   tdd_sync,
  input  logic                                   tdd_sync_rst,
  input  logic                                   tdd_sync_auto,
  input  logic [BURST_COUNT_WIDTH-1:0]           tdd_burst_count,
  input  logic [REGISTER_WIDTH-1:0]              tdd_startup_delay,
  input  logic [PW-1:0]                          tdd_profile_last,
  input  logic [NUM_PROFILES*REGISTER_WIDTH-1:0] tdd_frame_length,
  output logic [REGISTER_WIDTH-1:0]              tdd_counter,
  output logic [2:0]                             tdd_cstate,
  output logic [PW-1:0]                          tdd_profile_idx,
  output logic                                   tdd_endof_frame,
  output logic                                   tdd_endof_burst,
  output logic [BURST_COUNT_WIDTH-1:0]           tdd_burst_remaining
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_WAITING = 3'd2,
    ST_RUNNING = 3'd3,
    ST_STOPPED = 3'd4
  } state_t;

  localparam logic [REGISTER_WIDTH-1:0]    ONE_R   = 1;
  localparam logic [BURST_COUNT_WIDTH-1:0] ONE_B   = 1;
  localparam logic [PW-1:0]                ONE_P   = 1;
  localparam logic [PW-1:0]                MAX_IDX = PW'(NUM_PROFILES - 1);

  state_t                         state_q, state_d;
  logic [REGISTER_WIDTH-1:0]      counter_q, counter_d;
  logic [PW-1:0]                  idx_q, idx_d;
  logic [BURST_COUNT_WIDTH-1:0]   rem_q, rem_d;
  logic                           finite_q, finite_d;
  logic                           stop_pend_q, stop_pend_d;

  logic [REGISTER_WIDTH-1:0]      cur_len, last_cnt;
  logic [PW-1:0]                  last_clamped, idx_adv;
  logic                           endof_frame, endof_burst;
  logic                           wait_done, stop_now, resync, trigger, delay_zero;

  always_comb begin
    cur_len = '0;
    for (int p = 0; p < NUM_PROFILES; p++) begin
      if (idx_q == PW'(p)) cur_len = tdd_frame_length[p*REGISTER_WIDTH +: REGISTER_WIDTH];
    end
  end

  // A zero-length profile behaves as a single-cycle frame.
  assign last_cnt     = (cur_len == '0) ? '0 : cur_len - ONE_R;
  assign last_clamped = (tdd_profile_last > MAX_IDX) ? MAX_IDX : tdd_profile_last;
  assign idx_adv      = (idx_q >= last_clamped) ? '0 : idx_q + ONE_P;

  assign endof_frame = (state_q == ST_RUNNING) && (counter_q >= last_cnt);
  assign endof_burst = endof_frame && finite_q && (rem_q == ONE_B);

  assign delay_zero = (tdd_startup_delay == '0);
  assign wait_done  = delay_zero || (counter_q >= tdd_startup_delay - ONE_R);
  assign stop_now   = stop_pend_q || tdd_stop_req;
  assign trigger    = tdd_sync || tdd_sync_auto;
  assign resync     = tdd_sync && tdd_sync_rst &&
                      ((state_q == ST_WAITING) || (state_q == ST_RUNNING));

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    finite_d    = finite_q;
    stop_pend_d = stop_now;
    if (!tdd_enable) begin
      state_d     = ST_IDLE;
      counter_d   = '0;
      idx_d       = '0;
      rem_d       = '0;
      finite_d    = 1'b0;
      stop_pend_d = 1'b0;
    end else if (resync) begin
      // Stop request survives the resync and is carried to the next frame end.
      state_d   = delay_zero ? ST_RUNNING : ST_WAITING;
      counter_d = '0;
      idx_d     = '0;
      rem_d     = tdd_burst_count;
      finite_d  = (tdd_burst_count != '0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ARMED;
          counter_d = '0;
        end
        ST_ARMED: begin
          counter_d = '0;
          idx_d     = '0;
          if (stop_now) begin
            state_d     = ST_STOPPED;
            stop_pend_d = 1'b0;
          end else if (trigger) begin
            state_d  = delay_zero ? ST_RUNNING : ST_WAITING;
            rem_d    = tdd_burst_count;
            finite_d = (tdd_burst_count != '0);
          end
        end
        ST_WAITING: begin
          if (tdd_stop_req) begin
            state_d     = ST_STOPPED;
            counter_d   = '0;
            idx_d       = '0;
            stop_pend_d = 1'b0;
          end else if (wait_done) begin
            state_d   = ST_RUNNING;
            counter_d = '0;
          end else begin
            counter_d = counter_q + ONE_R;
          end
        end
        ST_RUNNING: begin
          if (endof_frame) begin
            counter_d = '0;
            if (finite_q && (rem_q != '0)) rem_d = rem_q - ONE_B;
            if (stop_now) begin
              state_d     = ST_STOPPED;
              idx_d       = '0;
              stop_pend_d = 1'b0;
            end else if (endof_burst) begin
              state_d = ST_ARMED;
              idx_d   = '0;
            end else begin
              idx_d = idx_adv;
            end
          end else begin
            counter_d = counter_q + ONE_R;
          end
        end
        ST_STOPPED: begin
          counter_d   = '0;
          idx_d       = '0;
          stop_pend_d = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = '0;
          idx_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      counter_q   <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      finite_q    <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      finite_q    <= finite_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign tdd_counter         = counter_q;
  assign tdd_cstate          = state_q;
  assign tdd_profile_idx     = idx_q;
  assign tdd_endof_frame     = endof_frame;
  assign tdd_endof_burst     = endof_burst;
  assign tdd_burst_remaining = rem_q;

endmodule

// File: tb/tb_axi_tdd_ng_sequencer.sv
// Directed bench for axi_tdd_ng_sequencer: bursts, profiles, infinite mode,
// auto re-arm, stop and resync scenarios.
module tb_axi_tdd_ng_sequencer;

  localparam int RW = 32;
  localparam int BW = 32;
  localparam int NP = 4;
  localparam int PW = 2;

  logic           clk;
  logic           resetn;
  logic           tdd_enable;
  logic           tdd_stop_req;
  logic           tdd_sync;
  logic           tdd_sync_rst;
  logic           tdd_sync_auto;
  logic [BW-1:0]  tdd_burst_count;
  logic [RW-1:0]  tdd_startup_delay;
  logic [PW-1:0]  tdd_profile_last;
  logic [NP*RW-1:0] tdd_frame_length;
  logic [RW-1:0]  tdd_counter;
  logic [2:0]     tdd_cstate;
  logic [PW-1:0]  tdd_profile_idx;
  logic           tdd_endof_frame;
  logic           tdd_endof_burst;
  logic [BW-1:0]  tdd_burst_remaining;

  int checks;
  int failures;

  axi_tdd_ng_sequencer #(
    .REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW), .NUM_PROFILES(NP)
  ) dut (
    .clk(clk), .resetn(resetn), .tdd_enable(tdd_enable), .tdd_stop_req(tdd_stop_req),
    .tdd_sync(tdd_sync), .tdd_sync_rst(tdd_sync_rst), .tdd_sync_auto(tdd_sync_auto),
    .tdd_burst_count(tdd_burst_count), .tdd_startup_delay(tdd_startup_delay),
    .tdd_profile_last(tdd_profile_last), .tdd_frame_length(tdd_frame_length),
    .tdd_counter(tdd_counter), .tdd_cstate(tdd_cstate), .tdd_profile_idx(tdd_profile_idx),
    .tdd_endof_frame(tdd_endof_frame), .tdd_endof_burst(tdd_endof_burst),
    .tdd_burst_remaining(tdd_burst_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forces IDLE, then leaves the DUT in ARMED.
  task automatic arm();
    tdd_enable = 1'b0;
    tick();
    tdd_enable = 1'b1;
    tick();
  endtask

  task automatic sync_pulse();
    tdd_sync = 1'b1;
    tick();
    tdd_sync = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tdd_enable = 1'b1;
    tick();
    tick();
    checks++;
    if ({tdd_cstate, tdd_counter, tdd_profile_idx, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst}
        !== {3'd0, 32'd0, 2'd0, 32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: state=%0d cnt=%0d idx=%0d rem=%0d eof=%b eob=%b, required all zero",
               tdd_cstate, tdd_counter, tdd_profile_idx, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst);
    end
    resetn = 1'b1;
  endtask

  task automatic test_burst_delay();
    tdd_startup_delay = 32'd3;
    tdd_frame_length  = {32'd0, 32'd0, 32'd0, 32'd5};
    tdd_profile_last  = 2'd0;
    tdd_burst_count   = 32'd2;
    arm();
    checks++;
    if (tdd_cstate !== 3'd1) begin
      failures++;
      $display("FAIL burst_armed: state=%0d required 1", tdd_cstate);
    end
    sync_pulse();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tdd_cstate, tdd_counter, tdd_burst_remaining} !== {3'd2, 32'(i), 32'd2}) begin
        failures++;
        $display("FAIL burst_wait[%0d]: state=%0d cnt=%0d rem=%0d, required 2/%0d/2",
                 i, tdd_cstate, tdd_counter, tdd_burst_remaining, i);
      end
      tick();
    end
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 5; c++) begin
        checks++;
        if ({tdd_cstate, tdd_counter, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst}
            !== {3'd3, 32'(c), 32'(2 - f), (c == 4), (c == 4 && f == 1)}) begin
          failures++;
          $display("FAIL burst_run[%0d.%0d]: state=%0d cnt=%0d rem=%0d eof=%b eob=%b, required 3/%0d/%0d/%b/%b",
                   f, c, tdd_cstate, tdd_counter, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst,
                   c, 2 - f, (c == 4), (c == 4 && f == 1));
        end
        tick();
      end
    end
    checks++;
    if ({tdd_cstate, tdd_counter, tdd_burst_remaining} !== {3'd1, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL burst_end: state=%0d cnt=%0d rem=%0d, required 1/0/0",
               tdd_cstate, tdd_counter, tdd_burst_remaining);
    end
  endtask

  task automatic test_profiles();
    int lens [4] = '{4, 6, 2, 1};
    tdd_startup_delay = 32'd0;
    tdd_frame_length  = {32'd0, 32'd2, 32'd6, 32'd4};
    tdd_profile_last  = 2'd3;
    tdd_burst_count   = 32'd4;
    arm();
    sync_pulse();
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < lens[f]; c++) begin
        checks++;
        if ({tdd_cstate, tdd_profile_idx, tdd_counter, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst}
            !== {3'd3, 2'(f), 32'(c), 32'(4 - f), (c == lens[f] - 1), (f == 3 && c == lens[f] - 1)}) begin
          failures++;
          $display("FAIL prof[%0d.%0d]: state=%0d idx=%0d cnt=%0d rem=%0d eof=%b eob=%b, required 3/%0d/%0d/%0d/%b/%b",
                   f, c, tdd_cstate, tdd_profile_idx, tdd_counter, tdd_burst_remaining, tdd_endof_frame,
                   tdd_endof_burst, f, c, 4 - f, (c == lens[f] - 1), (f == 3 && c == lens[f] - 1));
        end
        tick();
      end
    end
    checks++;
    if ({tdd_cstate, tdd_profile_idx} !== {3'd1, 2'd0}) begin
      failures++;
      $display("FAIL prof_end: state=%0d idx=%0d, required 1/0", tdd_cstate, tdd_profile_idx);
    end
  endtask

  task automatic test_infinite();
    tdd_startup_delay = 32'd0;
    tdd_frame_length  = {32'd0, 32'd0, 32'd0, 32'd3};
    tdd_profile_last  = 2'd0;
    tdd_burst_count   = 32'd0;
    tdd_sync_auto     = 1'b1;
    arm();
    tick();
    for (int i = 0; i < 330; i++) begin
      checks++;
      if ({tdd_cstate, tdd_counter, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst}
          !== {3'd3, 32'(i % 3), 32'd0, (i % 3 == 2), 1'b0}) begin
        failures++;
        $display("FAIL inf[%0d]: state=%0d cnt=%0d rem=%0d eof=%b eob=%b, required 3/%0d/0/%b/0",
                 i, tdd_cstate, tdd_counter, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst,
                 i % 3, (i % 3 == 2));
      end
      tick();
    end
    tdd_sync_auto = 1'b0;
  endtask

  task automatic test_back_to_back();
    tdd_startup_delay = 32'd0;
    tdd_frame_length  = {32'd0, 32'd0, 32'd0, 32'd2};
    tdd_profile_last  = 2'd0;
    tdd_burst_count   = 32'd1;
    tdd_sync_auto     = 1'b1;
    arm();
    for (int i = 0; i < 9; i++) begin
      logic [2:0]  exp_st;
      logic [31:0] exp_cnt;
      exp_st  = (i % 3 == 0) ? 3'd1 : 3'd3;
      exp_cnt = (i % 3 == 2) ? 32'd1 : 32'd0;
      checks++;
      if ({tdd_cstate, tdd_counter, tdd_endof_burst} !== {exp_st, exp_cnt, (i % 3 == 2)}) begin
        failures++;
        $display("FAIL b2b[%0d]: state=%0d cnt=%0d eob=%b, required %0d/%0d/%b",
                 i, tdd_cstate, tdd_counter, tdd_endof_burst, exp_st, exp_cnt, (i % 3 == 2));
      end
      tick();
    end
    tdd_sync_auto = 1'b0;
  endtask

  task automatic test_stop();
    tdd_startup_delay = 32'd0;
    tdd_frame_length  = {32'd0, 32'd0, 32'd0, 32'd8};
    tdd_profile_last  = 2'd0;
    tdd_burst_count   = 32'd0;
    arm();
    sync_pulse();
    tick();
    checks++;
    if ({tdd_cstate, tdd_counter} !== {3'd3, 32'd1}) begin
      failures++;
      $display("FAIL stop_c1: state=%0d cnt=%0d, required 3/1", tdd_cstate, tdd_counter);
    end
    tdd_stop_req = 1'b1;
    tick();
    tdd_stop_req = 1'b0;
    for (int c = 2; c < 8; c++) begin
      checks++;
      if ({tdd_cstate, tdd_counter, tdd_endof_frame} !== {3'd3, 32'(c), (c == 7)}) begin
        failures++;
        $display("FAIL stop_run[%0d]: state=%0d cnt=%0d eof=%b, required 3/%0d/%b",
                 c, tdd_cstate, tdd_counter, tdd_endof_frame, c, (c == 7));
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({tdd_cstate, tdd_counter, tdd_endof_frame} !== {3'd4, 32'd0, 1'b0}) begin
        failures++;
        $display("FAIL stopped[%0d]: state=%0d cnt=%0d eof=%b, required 4/0/0",
                 k, tdd_cstate, tdd_counter, tdd_endof_frame);
      end
      tick();
    end
    tdd_enable = 1'b0;
    tick();
    checks++;
    if ({tdd_cstate, tdd_counter} !== {3'd0, 32'd0}) begin
      failures++;
      $display("FAIL stop_idle: state=%0d cnt=%0d, required 0/0", tdd_cstate, tdd_counter);
    end
    tdd_enable = 1'b1;
    tdd_startup_delay = 32'd5;
    tick();
    sync_pulse();
    checks++;
    if ({tdd_cstate, tdd_counter} !== {3'd2, 32'd0}) begin
      failures++;
      $display("FAIL stop_wait_entry: state=%0d cnt=%0d, required 2/0", tdd_cstate, tdd_counter);
    end
    tdd_stop_req = 1'b1;
    tick();
    tdd_stop_req = 1'b0;
    checks++;
    if ({tdd_cstate, tdd_counter} !== {3'd4, 32'd0}) begin
      failures++;
      $display("FAIL stop_wait: state=%0d cnt=%0d, required 4/0", tdd_cstate, tdd_counter);
    end
  endtask

  task automatic test_resync();
    tdd_startup_delay = 32'd2;
    tdd_frame_length  = {32'd0, 32'd0, 32'd0, 32'd10};
    tdd_profile_last  = 2'd0;
    tdd_burst_count   = 32'd0;
    arm();
    sync_pulse();
    tick();
    tick();
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if ({tdd_cstate, tdd_counter} !== {3'd3, 32'd5}) begin
      failures++;
      $display("FAIL resync_pre: state=%0d cnt=%0d, required 3/5", tdd_cstate, tdd_counter);
    end
    tdd_sync = 1'b1;
    tdd_sync_rst = 1'b1;
    tdd_stop_req = 1'b1;
    tick();
    tdd_sync = 1'b0;
    tdd_sync_rst = 1'b0;
    tdd_stop_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({tdd_cstate, tdd_counter} !== {3'd2, 32'(i)}) begin
        failures++;
        $display("FAIL resync_wait[%0d]: state=%0d cnt=%0d, required 2/%0d", i, tdd_cstate, tdd_counter, i);
      end
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({tdd_cstate, tdd_counter, tdd_endof_frame} !== {3'd3, 32'(c), (c == 9)}) begin
        failures++;
        $display("FAIL resync_run[%0d]: state=%0d cnt=%0d eof=%b, required 3/%0d/%b",
                 c, tdd_cstate, tdd_counter, tdd_endof_frame, c, (c == 9));
      end
      tick();
    end
    checks++;
    if (tdd_cstate !== 3'd4) begin
      failures++;
      $display("FAIL resync_stop: state=%0d required 4", tdd_cstate);
    end
    tdd_startup_delay = 32'd0;
    tdd_burst_count   = 32'd3;
    arm();
    sync_pulse();
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if ({tdd_cstate, tdd_counter, tdd_burst_remaining} !== {3'd3, 32'd3, 32'd3}) begin
      failures++;
      $display("FAIL mid_run: state=%0d cnt=%0d rem=%0d, required 3/3/3",
               tdd_cstate, tdd_counter, tdd_burst_remaining);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if ({tdd_cstate, tdd_counter, tdd_profile_idx, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst}
        !== {3'd0, 32'd0, 2'd0, 32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: state=%0d cnt=%0d idx=%0d rem=%0d eof=%b eob=%b, required all zero",
               tdd_cstate, tdd_counter, tdd_profile_idx, tdd_burst_remaining, tdd_endof_frame, tdd_endof_burst);
    end
    resetn = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    tdd_enable = 1'b0;
    tdd_stop_req = 1'b0;
    tdd_sync = 1'b0;
    tdd_sync_rst = 1'b0;
    tdd_sync_auto = 1'b0;
    tdd_burst_count = '0;
    tdd_startup_delay = '0;
    tdd_profile_last = '0;
    tdd_frame_length = '0;
    #2;
    test_reset();
    test_burst_delay();
    test_profiles();
    test_infinite();
    test_back_to_back();
    test_stop();
    test_resync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
